// File: rtl/uart_pkg.sv
// Shared constants and the receiver state encoding for the UART receive path.
package uart_pkg;

    localparam int OVS        = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator: one-clock tick every CLK_HZ/(BAUD*16) clocks (minimum 1).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Clearing on the start edge phase-aligns every later tick to that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity checking.
// sgn is an active-low one-clock strobe marking the cycle data is updated.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       sgn,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output rx_state_e  o_dbg_state
);

    localparam logic [3:0] MID_CNT  = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST_CNT = 4'(OVS - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_e  r_state, w_state_nxt;
    logic       r_sync1, r_sync2, r_prev;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift, r_data;
    logic       r_sgn_n, r_frame_err, r_par_bad;
    logic       w_tick, w_fall, w_mid_start, w_mid_bit;
    logic       w_clr, w_shift_en, w_load, w_ferr, w_perr;

    uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall      = r_prev && !r_sync2;
    assign w_mid_start = w_tick && (r_tick_cnt == MID_CNT);
    assign w_mid_bit   = w_tick && (r_tick_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        w_perr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_clr       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_mid_start) w_state_nxt = r_sync2 ? IDLE : DATA;
            end
            DATA: begin
                if (w_mid_bit) begin
                    w_shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (r_bit_cnt == LAST_BIT) w_state_nxt = PARITY;
`else
                    if (r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_mid_bit) begin
                    w_perr      = (r_sync2 != ^r_shift);
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (w_mid_bit) begin
                    if (r_sync2) begin
                        w_load      = !r_par_bad;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (r_sync2) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_sgn_n     <= 1'b1;
            r_frame_err <= 1'b0;
            r_par_bad   <= 1'b0;
        end else begin
            r_sgn_n     <= !w_load;
            r_frame_err <= w_ferr;
            // Tick count restarts at mid start bit so later samples land mid-bit on 15.
            if (w_clr || (r_state == START && w_mid_start)) begin
                r_tick_cnt <= '0;
            end else if (w_tick && r_state != IDLE && r_state != WAIT_IDLE) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (w_clr) begin
                r_bit_cnt <= '0;
                r_par_bad <= 1'b0;
            end else if (w_perr) begin
                r_par_bad <= 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {r_sync2, r_shift[7:1]};
                if (r_bit_cnt != LAST_BIT) r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_load) r_data <= r_shift;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_parity_err <= 1'b0;
        else     r_parity_err <= w_perr;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data        = r_data;
    assign sgn         = r_sgn_n;
    assign busy        = (r_state != IDLE) || w_fall;
    assign frame_err   = r_frame_err;
    assign o_dbg_state = r_state;

endmodule
